// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  // Default divisor/remainder width; dividend and quotient are twice this.
  localparam int unsigned DIV_N_DEFAULT = 4;

  // Controller states; encodings kept from the original design.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift a bit into the partial remainder,
// trial-subtract the divisor, and keep the difference if it is non-negative.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEFAULT
) (
  input  logic [N:0]   p_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   p_o,
  output logic         q_o
);

  logic [N+1:0] shifted;
  logic [N+2:0] trial;

  // Trial subtraction is one bit wider than the shifted value so its MSB is the sign.
  always_comb begin
    shifted = {p_i, bit_i};
    trial   = {1'b0, shifted} - {3'b000, divisor_i};
    if (trial[N+2]) begin
      p_o = shifted[N:0];
      q_o = 1'b0;
    end else begin
      p_o = trial[N:0];
      q_o = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, with start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int unsigned   CW       = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(2 * N - 1);

  div_state_e     state_q;
  logic           busy_q;
  logic           done_q;
  logic [2*N-1:0] quot_q;
  logic [N-1:0]   rem_q;
  logic           dbz_q;

  // The working register starts as the dividend; its MSB feeds the step
  // each cycle while quotient bits enter at the LSB.
  logic [2*N-1:0] work_q;
  logic [N:0]     p_q;
  logic [N-1:0]   dvs_q;
  logic [CW-1:0]  cnt_q;

  logic [N:0]     p_d;
  logic           qbit_d;
  logic [2*N-1:0] work_d;

  div_step #(
    .N(N)
  ) u_step (
    .p_i      (p_q),
    .bit_i    (work_q[2*N-1]),
    .divisor_i(dvs_q),
    .p_o      (p_d),
    .q_o      (qbit_d)
  );

  assign work_d = {work_q[2*N-2:0], qbit_d};

  // Controller, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      work_q  <= '0;
      p_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        // DONE shares IDLE's acceptance path so back-to-back starts work.
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend[N-1:0];
              dbz_q   <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              work_q  <= dividend;
              p_q     <= '0;
              dvs_q   <= divisor;
              cnt_q   <= CNT_LOAD;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_q    <= p_d;
          work_q <= work_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= work_d;
            rem_q   <= p_d[N-1:0];
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=4).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  seq_divider #(
    .N(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [7:0] hold_q = '0;
  logic [3:0] hold_r = '0;
  logic       hold_z = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on done and checks held outputs otherwise.
  always @(posedge clk) begin
    logic r_s;
    exp_t e;
    r_s = rst_n;
    cyc++;
    #1;
    if (!r_s) begin
      hold_q = '0;
      hold_r = '0;
      hold_z = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency_cycle", cyc, e.cyc);
        chk("busy_at_done", busy, 0);
        hold_q = e.q;
        hold_r = e.r;
        hold_z = e.z;
      end
    end else begin
      chk("hold_quot", quotient, hold_q);
      chk("hold_rem", remainder, hold_r);
      chk("hold_dbz", div_by_zero, hold_z);
    end
  end

  // Called at a negedge: present operands for one cycle and record the expectation.
  task automatic drive_start(input logic [7:0] a, input logic [3:0] b,
                             input logic [7:0] eq, input logic [3:0] er,
                             input logic ez, input int lat);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.z   = ez;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, or flags a timeout.
  task automatic wait_done();
    int i = 0;
    while (!done && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_quot", quotient, 0);

    // Basic divisions from IDLE
    drive_start(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 9);  wait_done(); @(negedge clk);
    drive_start(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);  wait_done(); @(negedge clk);
    drive_start(8'd0, 4'd7, 8'd0, 4'd0, 1'b0, 9);      wait_done(); @(negedge clk);
    drive_start(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9);  wait_done(); @(negedge clk);

    // Divide by zero, then a normal division clears the flag
    drive_start(8'd100, 4'd0, 8'hFF, 4'd4, 1'b1, 1);   wait_done(); @(negedge clk);
    drive_start(8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 9);  wait_done(); @(negedge clk);

    // start during RUN is ignored
    drive_start(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 9);
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back: start accepted in the DONE cycle
    drive_start(8'd50, 4'd3, 8'd16, 4'd2, 1'b0, 9);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    wait_done(); @(negedge clk);

    // Reset mid-operation: no done, outputs cleared
    drive_start(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    repeat (12) @(negedge clk);
    drive_start(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9);    wait_done();

    // All non-zero divisor pairs, issued back-to-back
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        drive_start(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9);
        wait_done();
      end
    end

    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
